// File: rtl/weight_fetcher.sv
// Weight buffer read sequencer: issues one row read per advancing cycle and tracks the
// buffer's 3-cycle read latency. Optional build macro WEIGHT_FETCHER_ZERO_PAD_EN pads every tile to MATRIX_WIDTH rows.
module weight_fetcher #(
  parameter int MATRIX_WIDTH = 14,
  parameter int ADDR_WIDTH   = 40,
  parameter int LEN_WIDTH    = $clog2(MATRIX_WIDTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [ADDR_WIDTH-1:0]        cmd_addr,
  input  logic [LEN_WIDTH-1:0]         cmd_len,
  output logic [ADDR_WIDTH-1:0]        buf_addr,
  output logic                         buf_en,
  output logic                         buf_enable,
  input  logic [MATRIX_WIDTH-1:0][7:0] buf_rdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [MATRIX_WIDTH-1:0][7:0] out_data,
  output logic [LEN_WIDTH-1:0]         out_row,
  output logic                         out_last,
  output logic                         cmd_done
);

  // state | meaning
  // IDLE  | cmd_ready high, waiting for a command
  // ISSUE | one row read (or pad slot) issued per advancing cycle
  // DRAIN | all rows issued, waiting for the last row to leave the output
  // DONE  | cmd_done pulse (zero-length tiles spend one extra cycle here first)
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [LEN_WIDTH-1:0] MW = LEN_WIDTH'(MATRIX_WIDTH);

  state_t                          state;
  logic [LEN_WIDTH-1:0]            len_q;
  logic [LEN_WIDTH-1:0]            issue_cnt;
  logic [LEN_WIDTH-1:0]            total;
  logic [LEN_WIDTH-1:0]            len_c;
  logic [2:0]                      vld;
  logic [2:0][LEN_WIDTH-1:0]       row_p;
  logic [2:0]                      last_p;
  logic [2:0]                      pad_p;
  logic                            adv;
  logic                            issuing;
  logic                            issue_real;
  logic                            issue_last;

  assign len_c = (cmd_len > MW) ? MW : cmd_len;

`ifdef WEIGHT_FETCHER_ZERO_PAD_EN
  assign total = MW;
`else
  assign total = len_q;
`endif

  assign issuing    = (state == ISSUE);
  assign issue_real = (issue_cnt < len_q);
  assign issue_last = (issue_cnt == total - LEN_WIDTH'(1));

  // The buffer pipeline and our valid pipe freeze together on a stalled output row.
  assign adv        = !vld[2] || out_ready;
  assign buf_enable = adv;
  assign buf_en     = adv && issuing && issue_real;

  assign out_valid = vld[2];
  assign out_row   = row_p[2];
  assign out_last  = vld[2] && last_p[2];
  assign out_data  = (vld[2] && !pad_p[2]) ? buf_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      cmd_done  <= 1'b0;
      buf_addr  <= '0;
      len_q     <= '0;
      issue_cnt <= '0;
      vld       <= '0;
      row_p     <= '0;
      last_p    <= '0;
      pad_p     <= '0;
    end else begin
      if (adv) begin
        vld      <= {vld[1:0], issuing};
        row_p[2] <= row_p[1];
        row_p[1] <= row_p[0];
        row_p[0] <= issuing ? issue_cnt : '0;
        last_p   <= {last_p[1:0], issuing && issue_last};
        pad_p    <= {pad_p[1:0], issuing && !issue_real};
      end

      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            buf_addr  <= cmd_addr;
            len_q     <= len_c;
            issue_cnt <= '0;
            cmd_ready <= 1'b0;
`ifdef WEIGHT_FETCHER_ZERO_PAD_EN
            state     <= ISSUE;
`else
            state     <= (len_c == '0) ? DONE : ISSUE;
`endif
          end
        end
        ISSUE: begin
          if (adv) begin
            issue_cnt <= issue_cnt + LEN_WIDTH'(1);
            buf_addr  <= buf_addr + ADDR_WIDTH'(1);
            if (issue_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (vld[2] && last_p[2] && out_ready) begin
            state    <= DONE;
            cmd_done <= 1'b1;
          end
        end
        DONE: begin
          if (cmd_done) begin
            cmd_done  <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            cmd_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
